// File: rtl/alu_writeback.sv
// ALU writeback stage: latches masked ALU flags into the status register,
// queues register-file writes in a 2-entry FIFO, and evaluates branch
// conditions against the registered status.
module alu_writeback #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  I_CLK,
   input  logic                  I_RESET,
   input  logic                  I_VALID,
   output logic                  O_READY,
   input  logic [DATA_WIDTH-1:0] I_C,
   input  logic [4:0]            I_STATUS,
   input  logic [4:0]            I_FLAG_MASK,
   input  logic [3:0]            I_DEST,
   input  logic                  I_WB_EN,
   output logic                  O_WB_VALID,
   input  logic                  I_WB_READY,
   output logic [DATA_WIDTH-1:0] O_WB_DATA,
   output logic [3:0]            O_WB_DEST,
   output logic [4:0]            O_PSR,
   input  logic [3:0]            I_COND,
   output logic                  O_COND_TRUE
);

   // FIFO storage is never reset; validity is tracked by count_q alone
   logic [DATA_WIDTH-1:0] dataMem_q [2];
   logic [3:0]            destMem_q [2];

   logic       wrPtr_q, wrPtr_d;
   logic       rdPtr_q, rdPtr_d;
   logic [1:0] count_q, count_d;
   logic [4:0] psr_q, psr_d;

   logic accept;
   logic push;
   logic pop;

   logic flagC, flagL, flagF, flagZ, flagN;

   // Ready depends only on occupancy so the register file's ready never
   // ripples back into the ALU handshake
   assign O_READY    = (count_q < 2'd2);
   assign O_WB_VALID = (count_q != 2'd0);
   assign O_WB_DATA  = dataMem_q[rdPtr_q];
   assign O_WB_DEST  = destMem_q[rdPtr_q];
   assign O_PSR      = psr_q;

   assign accept = I_VALID & O_READY;
   assign push   = accept & I_WB_EN;
   assign pop    = O_WB_VALID & I_WB_READY;

   assign flagC = psr_q[0];
   assign flagL = psr_q[1];
   assign flagF = psr_q[2];
   assign flagZ = psr_q[3];
   assign flagN = psr_q[4];

   // Next-state for pointers, occupancy and the masked status update
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      psr_d   = psr_q;
      if (push) begin
         wrPtr_d = ~wrPtr_q;
      end
      if (pop) begin
         rdPtr_d = ~rdPtr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (accept) begin
         psr_d = (psr_q & ~I_FLAG_MASK) | (I_STATUS & I_FLAG_MASK);
      end
   end

   // Control state, cleared asynchronously so queued writes are discarded
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
         psr_q   <= 5'b00000;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         psr_q   <= psr_d;
      end
   end

   // Write the accepted result into the slot under the write pointer
   always_ff @(posedge I_CLK) begin
      if (push) begin
         dataMem_q[wrPtr_q] <= I_C;
         destMem_q[wrPtr_q] <= I_DEST;
      end
   end

   // Branch condition decode against the registered flags
   always_comb begin
      O_COND_TRUE = 1'b0;
      case (I_COND)
         4'b0000: O_COND_TRUE = flagZ;
         4'b0001: O_COND_TRUE = ~flagZ;
         4'b0010: O_COND_TRUE = flagC;
         4'b0011: O_COND_TRUE = ~flagC;
         4'b0100: O_COND_TRUE = flagL;
         4'b0101: O_COND_TRUE = ~flagL;
         4'b0110: O_COND_TRUE = flagN;
         4'b0111: O_COND_TRUE = ~flagN;
         4'b1000: O_COND_TRUE = flagF;
         4'b1001: O_COND_TRUE = ~flagF;
         4'b1010: O_COND_TRUE = ~flagL & ~flagZ;
         4'b1011: O_COND_TRUE = flagL | flagZ;
         4'b1100: O_COND_TRUE = ~flagN & ~flagZ;
         4'b1101: O_COND_TRUE = flagN | flagZ;
         4'b1110: O_COND_TRUE = 1'b1;
         default: O_COND_TRUE = 1'b0;
      endcase
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the result and writeback data width.
REQ-002 The module SHALL have port I_CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port I_RESET, input, 1, the asynchronous active-high reset.
REQ-004 The module SHALL have port I_VALID, input, 1, meaning an ALU result is offered this cycle.
REQ-005 The module SHALL have port O_READY, output, 1, meaning an offered result is accepted this cycle.
REQ-006 The module SHALL have port I_C, input, DATA_WIDTH, the ALU result.
REQ-007 The module SHALL have port I_STATUS, input, 5, the ALU flags: bit0 carry, bit1 low, bit2 flag/overflow, bit3 zero, bit4 negative.
REQ-008 The module SHALL have port I_FLAG_MASK, input, 5, per-bit enable for PSR update.
REQ-009 The module SHALL have port I_DEST, input, 4, the destination register index.
REQ-010 The module SHALL have port I_WB_EN, input, 1, meaning the result is written to the register file (0 means flags-only, e.g. CMP).
REQ-011 The module SHALL have port O_WB_VALID, output, 1, meaning a register write is presented.
REQ-012 The module SHALL have port I_WB_READY, input, 1, meaning the register file accepts the write.
REQ-013 The module SHALL have port O_WB_DATA, output, DATA_WIDTH, the write data.
REQ-014 The module SHALL have port O_WB_DEST, output, 4, the write register index.
REQ-015 The module SHALL have port O_PSR, output, 5, the registered status, in the same bit order as I_STATUS.
REQ-016 The module SHALL have port I_COND, input, 4, the branch condition code.
REQ-017 The module SHALL have port O_COND_TRUE, output, 1, the condition evaluated against O_PSR.

Function
REQ-018 Acceptance SHALL occur when I_VALID and O_READY are both 1 at a rising edge; the handshake is valid/ready with no combinational ready-to-valid dependency.
REQ-019 O_READY SHALL be 1 iff the internal 2-entry FIFO count is below 2; it SHALL NOT depend combinationally on I_WB_READY.
REQ-020 On acceptance, each PSR bit k with I_FLAG_MASK[k]=1 SHALL take I_STATUS[k] at that edge; unmasked bits SHALL hold; O_PSR changes exactly 1 cycle after acceptance.
REQ-021 On acceptance with I_WB_EN=1, {I_C, I_DEST} SHALL be pushed into the FIFO; with I_WB_EN=0 no push SHALL occur and the PSR update alone is performed.
REQ-022 O_WB_VALID SHALL be 1 iff count>0, and O_WB_DATA/O_WB_DEST SHALL present the FIFO head.
REQ-023 A pop SHALL occur when O_WB_VALID and I_WB_READY are both 1 at an edge.
REQ-024 On a simultaneous push and pop, count SHALL be unchanged and order SHALL be preserved.
REQ-025 When full, pop-only SHALL leave count=1 and assert O_READY the next cycle.
REQ-026 Writes SHALL retire in acceptance order; no entry SHALL be dropped or duplicated; the head SHALL be held stable while O_WB_VALID=1 and I_WB_READY=0.
REQ-027 FIFO read/write pointers SHALL be 1 bit wide, wrap modulo 2, and count SHALL never exceed 2 or underflow.
REQ-028 O_COND_TRUE SHALL be purely combinational from O_PSR and I_COND, with C,L,F,Z,N = O_PSR[0..4]:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 HI L; 0101 LS !L
- 0110 GT N; 0111 LE !N; 1000 FS F; 1001 FC !F; 1010 LO !L&!Z; 1011 HS L|Z
- 1100 LT !N&!Z; 1101 GE N|Z; 1110 UC 1; 1111 never 0
REQ-029 I_C, I_STATUS, I_DEST, I_FLAG_MASK and I_WB_EN SHALL be ignored when no acceptance occurs.

Reset
REQ-030 When I_RESET is asserted, the block SHALL asynchronously set O_PSR=5'b00000, count=0, both pointers=0, O_WB_VALID=0 and O_READY=1, regardless of the clock.
REQ-031 Reset asserted mid-operation SHALL discard all queued writes; no write SHALL be presented after reset release until a new acceptance.
REQ-032 FIFO storage contents MAY be left unreset; O_WB_DATA and O_WB_DEST are don't-care while O_WB_VALID=0.

Verification
REQ-033 The bench SHALL cover this case: accept C=16'h0000, STATUS=5'b01000, mask=5'b11111, WB_EN=1, DEST=3 with I_WB_READY=1 -> next cycle O_PSR=01000, O_WB_VALID=1, data 0, dest 3; I_COND=0000 gives O_COND_TRUE=1.
REQ-034 The bench SHALL cover this case: I_WB_READY=0 and three back-to-back offers A,B,C -> A and B accepted, O_READY=0 while C is held; after releasing ready, writes retire as A,B,C in order with no gaps beyond one cycle.
REQ-035 The bench SHALL cover this case: flags-only accept (WB_EN=0) with mask=5'b00011 and STATUS=5'b10011 from PSR=01000 -> PSR=01011, and no O_WB_VALID pulse.
REQ-036 The bench SHALL cover this case: count=1 with a simultaneous push and pop for 10 cycles -> count stays 1, O_READY stays 1, and data emerges in order.
REQ-037 The bench SHALL cover this case: all 16 I_COND values for each of the 32 PSR values -> O_COND_TRUE matches the REQ-028 table exactly.
REQ-038 The bench SHALL cover this case: I_RESET pulsed between clock edges with 2 entries queued -> O_WB_VALID=0, O_PSR=0 and O_READY=1 immediately, and no stale write after release.
